cache_req_arbiter: RTL

//  Round-robin arbiter sharing the single CPU-side port of PhysicalCache among NUM_REQ requesters
//  (e.g. instruction fetch, load/store, debug). Grants one request at a time, holds it on the cache

---
 rtl/cache_req_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter
// Round-robin arbiter that shares the single CPU-side port of PhysicalCache
// among NUM_REQ requesters. One request is granted at a time. The request is
// held on the cache port until hit_CPU completes it. The result is then
// returned to the granted requester. A watchdog aborts requests that the
// cache never completes.
module cache_req_arbiter #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int CACHE_LINE_SIZE = 32,
  parameter int NUM_REQ         = 2,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_address,
  input  logic [NUM_REQ*CACHE_LINE_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]                 req_wen,
  output logic [NUM_REQ-1:0]                 resp_valid,
  output logic                               resp_err,
  output logic [CACHE_LINE_SIZE-1:0]         resp_data,
  output logic                               reqValid_CPU,
  output logic [ADDRESS_WIDTH-1:0]           address_in_CPU,
  output logic [CACHE_LINE_SIZE-1:0]         data_in_CPU,
  output logic                               wen_CPU,
  input  logic [CACHE_LINE_SIZE-1:0]         data_out_CPU,
  input  logic                               hit_CPU,
  output logic                               busy,
  output logic                               timeout_error
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  // Last BUSY cycle index before the watchdog aborts. This is unused when the watchdog is off.
  localparam logic [CNT_W-1:0] WD_LAST = WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} arbStateT;

  arbStateT                   arbState;
  logic [IDX_W-1:0]           rrPtr;
  logic [IDX_W-1:0]           grantIdx;
  logic [CNT_W-1:0]           wdCount;
  logic                       winnerFound;
  logic [IDX_W-1:0]           winnerIdx;
  logic [IDX_W-1:0]           candIdx;
  logic [NUM_REQ-1:0]         grantMask;
  logic [ADDRESS_WIDTH-1:0]   reqAddrArr [NUM_REQ];
  logic [CACHE_LINE_SIZE-1:0] reqDataArr [NUM_REQ];

  // Unpack the flat requester buses. Build a one-hot mask of the granted requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gPerReq
    assign reqAddrArr[gi] = req_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign reqDataArr[gi] = req_data[gi*CACHE_LINE_SIZE +: CACHE_LINE_SIZE];
    assign grantMask[gi]  = (grantIdx == IDX_W'(gi));
  end

  // Round-robin search. The scan starts at the requester after the last winner.
  always_comb begin
    winnerFound = 1'b0;
    winnerIdx   = '0;
    candIdx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      candIdx = IDX_W'((int'(rrPtr) + k) % NUM_REQ);
      if (!winnerFound && req_valid[candIdx]) begin
        winnerFound = 1'b1;
        winnerIdx   = candIdx;
      end
    end
  end

  // Grant is offered only in IDLE. It is forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst && arbState == IDLE && winnerFound) begin
      req_ready[winnerIdx] = 1'b1;
    end
  end

  // Main controller: grant, hold the request on the cache port, respond for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arbState       <= IDLE;
      rrPtr          <= IDX_W'(NUM_REQ - 1);
      grantIdx       <= '0;
      wdCount        <= '0;
      address_in_CPU <= '0;
      data_in_CPU    <= '0;
      wen_CPU        <= 1'b0;
      reqValid_CPU   <= 1'b0;
      busy           <= 1'b0;
      resp_valid     <= '0;
      resp_err       <= 1'b0;
      resp_data      <= '0;
      timeout_error  <= 1'b0;
    end else begin
      case (arbState)
        IDLE: begin
          if (winnerFound) begin
            address_in_CPU <= reqAddrArr[winnerIdx];
            data_in_CPU    <= reqDataArr[winnerIdx];
            wen_CPU        <= req_wen[winnerIdx];
            grantIdx       <= winnerIdx;
            rrPtr          <= winnerIdx;
            wdCount        <= '0;
            reqValid_CPU   <= 1'b1;
            busy           <= 1'b1;
            arbState       <= BUSY;
          end
        end
        BUSY: begin
          if (hit_CPU) begin
            // A hit wins even on the cycle where the watchdog would expire.
            resp_data    <= data_out_CPU;
            resp_err     <= 1'b0;
            resp_valid   <= grantMask;
            reqValid_CPU <= 1'b0;
            arbState     <= DONE;
          end else if (WD_EN && wdCount == WD_LAST) begin
            resp_data     <= '0;
            resp_err      <= 1'b1;
            timeout_error <= 1'b1;
            resp_valid    <= grantMask;
            reqValid_CPU  <= 1'b0;
            arbState      <= DONE;
          end else begin
            wdCount <= wdCount + CNT_W'(1);
          end
        end
        DONE: begin
          // The response cycle also forces a one-cycle gap on the cache port.
          resp_valid <= '0;
          resp_err   <= 1'b0;
          busy       <= 1'b0;
          arbState   <= IDLE;
        end
        default: arbState <= IDLE;
      endcase
    end
  end

endmodule
